uart_rx_word: RTL
=================

Name: uart_rx_word

Overview:
- UART receiver for the core's host-input path. Its words are consumed by the LWC2 instruction.
- Deserialises 8N1 bytes from the host, packs every 4 bytes into one 32-bit word, and buffers the words in a small FIFO.
- Hands one word per request to the decode stage over the uart_recv_ready / uart_recv_valid / uart_recv_data handshake.
- It is the counterpart of the uart_tx send path.

Parameters:
- CLK_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200 baud). Must be >= 8.
- DEPTH, 4: word FIFO depth. Must be a power of 2, >= 2.

Ports:
- clk  input  1  system clock.
- rstn  input  1  synchronous active-low reset.
- rxd  input  1  serial line from host, asynchronous, idles high.
- uart_recv_ready  input  1  request from decode (level).
- uart_recv_valid  output  1  one-cycle pulse: uart_recv_data holds a word.
- uart_recv_data  output  32  delivered word.
- overrun  output  1  sticky: a completed word was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- fifo_count  output  $clog2(DEPTH)+1  words currently buffered.

Behaviour:
- Interface convention: one clock; reset is synchronous and active-low. Ports are clk and rstn; all state updates on posedge clk.
- Reset (rstn=0 at a clock edge):
  - all outputs go to 0;
  - FIFO empty, byte counter 0, request latch cleared, bit FSM in IDLE.
  - Reset mid-frame discards the partial byte and the partial word.
- Input synchroniser: rxd passes through 2 flops to give rx_s. The previous-sample flop resets to 0, so a line held low through reset is not taken as a start bit until it has been seen high.
- Bit FSM (in the uart_rx_byte sub-module), with a cycle counter cnt and a bit index:
  - IDLE: on a falling edge of rx_s, go to START with cnt=0.
  - START: at cnt=CLK_PER_BIT/2-1, sample rx_s. If 1 (false start), go to IDLE. If 0, go to DATA with cnt=0 and bit=0.
  - DATA: at cnt=CLK_PER_BIT-1, shift rx_s into the byte (LSB first), then bit+1. After bit 7, go to STOP.
  - STOP: at cnt=CLK_PER_BIT-1 (mid stop bit), sample rx_s and return to IDLE in the same edge, so the next start can resync early.
    - If 1: byte_valid pulses for 1 cycle.
    - If 0: frame_err pulses, the byte is dropped, and the byte counter is unchanged.
- Word packing:
  - byte_cnt runs 0..3. Byte k is written to word bits [8k+7:8k]; the first received byte is the LSB byte.
  - On the 4th byte: push the word into the FIFO and set byte_cnt to 0.
  - If the FIFO is full with no simultaneous pop, the word is discarded and overrun is set to 1 until reset.
  - Simultaneous push and pop while full: both happen, no overrun.
- FIFO:
  - DEPTH entries, with pointers 1 bit wider than the address; wrap-around is by natural overflow.
  - A word pushed at edge N is visible for a pop decision at edge N+1.
  - fifo_count is registered and updates on the same edge as the push/pop.
- Request handshake:
  - A request is armed on a 0->1 transition of uart_recv_ready (the registered previous ready resets to 0).
  - Each armed request delivers exactly one word; holding ready high does not deliver more.
  - Delivery: armed and FIFO non-empty at edge N. At that edge, pop, load uart_recv_data with the head word, set uart_recv_valid=1 and disarm. uart_recv_valid returns to 0 at edge N+1.
  - uart_recv_data holds its value until the next delivery.
  - If armed while the FIFO is empty, the request stays armed until a word is pushed; delivery follows 1 cycle after the push.
  - A new rising edge of ready while already armed has no extra effect.
- Data paths are unsigned bit-packing only; there is no arithmetic on data.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  - constants for the default CLK_PER_BIT.
- One sub-module, uart_rx_byte: synchroniser plus bit FSM. Outputs byte_valid, byte_data[7:0] and frame_err.
- The FIFO, packing and handshake logic live in uart_rx_word.

Test Plan (CLK_PER_BIT=16, DEPTH=4):
- Send bytes 0x78,0x56,0x34,0x12, then pulse ready 0->1 -> a single uart_recv_valid pulse with data 0x12345678; fifo_count goes 1->0; holding ready high yields no second pulse.
- Raise ready with the FIFO empty, then send 0xEF,0xBE,0xAD,0xDE -> valid exactly 1 cycle after the push, data 0xDEADBEEF.
- 3-cycle low glitch on idle rxd -> no byte accepted and byte_cnt stays 0; then a full word 0x00000001 is received correctly.
- Byte with stop bit forced to 0 -> frame_err pulses once and the byte is dropped. The following 4 good bytes 0x11,0x22,0x33,0x44 form word 0x44332211.
- Send 5 words with no requests -> fifo_count=4 and overrun=1. Four requests then return words 1-4 in order; word 5 is lost.
- Assert rstn=0 for 1 cycle after 2 bytes of a word -> all outputs 0. The next 4 bytes 0xAA,0xBB,0xCC,0xDD form word 0xDDCCBBAA.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the host-input UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int CLK_PER_BIT_DEFAULT = 868;
  localparam int FIFO_DEPTH_DEFAULT  = 4;

endpackage

// File: rtl/uart_rx_word_if.sv
// Word delivery handshake between the UART receiver and the decode stage.
interface uart_rx_word_if;
  logic        uart_recv_ready;
  logic        uart_recv_valid;
  logic [31:0] uart_recv_data;

  modport master (input uart_recv_ready, output uart_recv_valid, output uart_recv_data);
  modport slave  (output uart_recv_ready, input uart_recv_valid, input uart_recv_data);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: two-flop synchroniser followed by the bit FSM.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLK_PER_BIT - 1);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta, rx_s, rx_prev;

  // All sync flops reset low so a line held low through reset is never seen as a start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_meta    <= 1'b0;
      rx_s       <= 1'b0;
      rx_prev    <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rxd;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_TC) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_TC) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is caught early.
          if (cnt == FULL_TC) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word.sv
// Host-input UART receiver: packs four bytes LSB-first into a word and
// buffers words in a FIFO, delivering one word per rising edge of ready.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int DEPTH       = FIFO_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rxd,
  uart_rx_word_if.master         recv,
  output logic                   overrun,
  output logic                   frame_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [31:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_lo;
  logic          ready_q, armed;
  logic          fifo_empty, fifo_full, push_word, push, pop, ready_rise;

  uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_byte (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always_comb begin
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == (AW+1)'(DEPTH));
    push_word  = byte_valid && (byte_cnt == 2'd3);
    pop        = armed && !fifo_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
    push       = push_word && (!fifo_full || pop);
    ready_rise = recv.uart_recv_ready && !ready_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {byte_data, word_lo};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fifo_count           <= '0;
      byte_cnt             <= '0;
      word_lo              <= '0;
      ready_q              <= 1'b0;
      armed                <= 1'b0;
      overrun              <= 1'b0;
      recv.uart_recv_valid <= 1'b0;
      recv.uart_recv_data  <= '0;
    end else begin
      ready_q              <= recv.uart_recv_ready;
      recv.uart_recv_valid <= 1'b0;

      if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    word_lo[7:0]   <= byte_data;
          2'd1:    word_lo[15:8]  <= byte_data;
          2'd2:    word_lo[23:16] <= byte_data;
          default: ;
        endcase
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push_word && !push) overrun <= 1'b1;

      if (pop) begin
        recv.uart_recv_data  <= mem[rd_ptr[AW-1:0]];
        recv.uart_recv_valid <= 1'b1;
        rd_ptr               <= rd_ptr + 1'b1;
      end

      armed <= pop ? 1'b0 : (armed || ready_rise);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
